// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout for the cellular-automaton frame buffer. Each buffer word
// holds 16 cells drawn as 2x2 pixels, and a programmable start row scrolls the screen.
module vga_scanout #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  start_row,
  output logic [12:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WORDS_PER_ROW = H_ACTIVE / 32;
  localparam int ROWS          = V_ACTIVE / 2;
  localparam int SCREEN_WORDS  = WORDS_PER_ROW * ROWS;

  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT_END    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEGIN     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END       = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEGIN     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END       = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] ROW_STEP     = 13'(WORDS_PER_ROW);
  localparam logic [12:0] SCREEN_LIMIT = 13'(SCREEN_WORDS);
  localparam logic [8:0]  ROW_LIMIT    = 9'(ROWS);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [12:0] row_base_q, row_base_d;
  logic [12:0] row_step_s, start_base_s;
  logic        h_last_s, v_last_s;
  logic        active_s, hsync_raw_s, vsync_raw_s, origin_s;

  logic [3:0]  idx1_q, idx1_d;
  logic        active1_q, hsync1_q, vsync1_q, origin1_q;

  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, frame_start_q;

  // Raster position decode.
  always_comb begin
    h_last_s    = (h_cnt_q == H_LAST);
    v_last_s    = (v_cnt_q == V_LAST);
    active_s    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    hsync_raw_s = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
    vsync_raw_s = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
    origin_s    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    idx1_d      = 4'd15 - h_cnt_q[4:1];
  end

  // Next counter values and scroll base; a logical row spans two scan lines,
  // so the base only advances after odd active lines.
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;
    row_step_s = row_base_q + ROW_STEP;
    if ({1'b0, start_row} < ROW_LIMIT) begin
      start_base_s = 13'(start_row) * ROW_STEP;
    end else begin
      start_base_s = 13'd0;
    end
    if (h_last_s) begin
      h_cnt_d = 10'd0;
      if (v_last_s) begin
        v_cnt_d    = 10'd0;
        row_base_d = start_base_s;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
        if ((v_cnt_q < V_ACT_END) && v_cnt_q[0]) begin
          if (row_step_s >= SCREEN_LIMIT) begin
            row_base_d = row_step_s - SCREEN_LIMIT;
          end else begin
            row_base_d = row_step_s;
          end
        end else begin
          row_base_d = row_base_q;
        end
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      row_base_q <= 13'd0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;
    end
  end

  // The buffer answers one cycle later, when stage 1 holds this pixel's bit index.
  always_comb begin
    if (active_s) begin
      rd_addr = row_base_q + {8'd0, h_cnt_q[9:5]};
    end else begin
      rd_addr = 13'd0;
    end
  end

  always_comb begin
    if (active1_q) begin
      rgb_d = rd_data[idx1_q] ? FG_COLOR : BG_COLOR;
    end else begin
      rgb_d = 12'h000;
    end
  end

  // Two-stage pipeline keeps sync and pixel data mutually aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx1_q        <= 4'd0;
      active1_q     <= 1'b0;
      hsync1_q      <= 1'b1;
      vsync1_q      <= 1'b1;
      origin1_q     <= 1'b0;
      rgb_q         <= 12'h000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      idx1_q        <= idx1_d;
      active1_q     <= active_s;
      hsync1_q      <= hsync_raw_s;
      vsync1_q      <= vsync_raw_s;
      origin1_q     <= origin_s;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync1_q;
      vsync_q       <= vsync1_q;
      frame_start_q <= origin1_q;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance runs many whole frames and a
// full-size instance runs the first lines, both against an arithmetic screen model.
module tb_vga_scanout;

  localparam int SHA = 96, SHFP = 8, SHS = 16, SHBP = 8;
  localparam int SVA = 20, SVFP = 2, SVS = 3, SVBP = 3;
  localparam int SHT = SHA + SHFP + SHS + SHBP;
  localparam int SVT = SVA + SVFP + SVS + SVBP;
  localparam int SFT = SHT * SVT;
  localparam int SWPR = SHA / 32;
  localparam int SROWS = SVA / 2;

  localparam int DHA = 640, DHFP = 16, DHS = 96, DHBP = 48;
  localparam int DVA = 480, DVFP = 10, DVS = 2, DVBP = 33;
  localparam int DHT = 800, DVT = 525, DFT = DHT * DVT;
  localparam int DWPR = 20, DROWS = 240;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_start_row, d_start_row;
  logic [12:0] s_rd_addr, d_rd_addr;
  logic [15:0] s_rd_data = 16'h0000, d_rd_data = 16'h0000;
  logic        s_hsync, s_vsync, s_frame_start, d_hsync, d_vsync, d_frame_start;
  logic [11:0] s_rgb, d_rgb;

  logic [15:0] mem_s [0:8191];
  logic [15:0] mem_d [0:8191];
  int          fsr_s [0:31];
  int          fsr_d [0:31];
  int          k;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP),
    .FG_COLOR(FG), .BG_COLOR(BG)
  ) u_small (
    .clk(clk), .rst(rst), .start_row(s_start_row), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .hsync(s_hsync), .vsync(s_vsync), .rgb(s_rgb),
    .frame_start(s_frame_start)
  );

  vga_scanout u_full (
    .clk(clk), .rst(rst), .start_row(d_start_row), .rd_addr(d_rd_addr),
    .rd_data(d_rd_data), .hsync(d_hsync), .vsync(d_vsync), .rgb(d_rgb),
    .frame_start(d_frame_start)
  );

  always @(posedge clk) begin
    s_rd_data <= mem_s[s_rd_addr];
    d_rd_data <= mem_d[d_rd_addr];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s at t=%0t k=%0d: got %0h, expected %0h", tag, $time, k, got, exp);
    end
  endtask

  function automatic bit m_active(int p, int ht, int vt, int ha, int va);
    return ((p % ht) < ha) && (((p / ht) % vt) < va);
  endfunction

  function automatic int m_addr(int p, int ht, int vt, int ha, int va, int wpr, int rows, int sr);
    int h = p % ht;
    int v = (p / ht) % vt;
    if (!m_active(p, ht, vt, ha, va)) return 0;
    return ((sr + v / 2) % rows) * wpr + h / 32;
  endfunction

  function automatic bit m_sync_low(int c, int a, int fp, int w);
    return (c >= a + fp) && (c < a + fp + w);
  endfunction

  always @(negedge clk) begin : s_chk
    int p, q, f, g, a2, bitn;
    logic [15:0] w;
    if (rst) begin
      fsr_s[0] <= 0;
      check_eq("s_rst_addr", 32'(s_rd_addr), 32'd0);
      check_eq("s_rst_hsync", 32'(s_hsync), 32'd1);
      check_eq("s_rst_vsync", 32'(s_vsync), 32'd1);
      check_eq("s_rst_rgb", 32'(s_rgb), 32'd0);
      check_eq("s_rst_fs", 32'(s_frame_start), 32'd0);
    end else begin
      p = k;
      f = p / SFT;
      check_eq("s_addr", 32'(s_rd_addr), 32'(m_addr(p, SHT, SVT, SHA, SVA, SWPR, SROWS, fsr_s[f])));
      if ((p % SFT) == SFT - 1)
        fsr_s[f + 1] <= (int'(s_start_row) < SROWS) ? int'(s_start_row) : 0;
      if (p < 2) begin
        check_eq("s_idle_hsync", 32'(s_hsync), 32'd1);
        check_eq("s_idle_vsync", 32'(s_vsync), 32'd1);
        check_eq("s_idle_rgb", 32'(s_rgb), 32'd0);
        check_eq("s_idle_fs", 32'(s_frame_start), 32'd0);
      end else begin
        q = p - 2;
        g = q / SFT;
        a2 = m_addr(q, SHT, SVT, SHA, SVA, SWPR, SROWS, fsr_s[g]);
        w = mem_s[a2];
        bitn = 15 - ((q % SHT) % 32) / 2;
        check_eq("s_rgb", 32'(s_rgb),
                 32'(m_active(q, SHT, SVT, SHA, SVA) ? (w[bitn] ? FG : BG) : 12'h000));
        check_eq("s_hsync", 32'(s_hsync), 32'(!m_sync_low(q % SHT, SHA, SHFP, SHS)));
        check_eq("s_vsync", 32'(s_vsync), 32'(!m_sync_low((q / SHT) % SVT, SVA, SVFP, SVS)));
        check_eq("s_fs", 32'(s_frame_start), 32'((q % SFT) == 0));
      end
    end
  end

  always @(negedge clk) begin : d_chk
    int p, q, f, g, a2, bitn;
    logic [15:0] w;
    if (rst) begin
      fsr_d[0] <= 0;
      check_eq("d_rst_addr", 32'(d_rd_addr), 32'd0);
      check_eq("d_rst_hsync", 32'(d_hsync), 32'd1);
      check_eq("d_rst_rgb", 32'(d_rgb), 32'd0);
    end else begin
      p = k;
      f = p / DFT;
      check_eq("d_addr", 32'(d_rd_addr), 32'(m_addr(p, DHT, DVT, DHA, DVA, DWPR, DROWS, fsr_d[f])));
      if ((p % DFT) == DFT - 1)
        fsr_d[f + 1] <= (int'(d_start_row) < DROWS) ? int'(d_start_row) : 0;
      if (p < 2) begin
        check_eq("d_idle_hsync", 32'(d_hsync), 32'd1);
        check_eq("d_idle_rgb", 32'(d_rgb), 32'd0);
        check_eq("d_idle_fs", 32'(d_frame_start), 32'd0);
      end else begin
        q = p - 2;
        g = q / DFT;
        a2 = m_addr(q, DHT, DVT, DHA, DVA, DWPR, DROWS, fsr_d[g]);
        w = mem_d[a2];
        bitn = 15 - ((q % DHT) % 32) / 2;
        check_eq("d_rgb", 32'(d_rgb),
                 32'(m_active(q, DHT, DVT, DHA, DVA) ? (w[bitn] ? FG : BG) : 12'h000));
        check_eq("d_hsync", 32'(d_hsync), 32'(!m_sync_low(q % DHT, DHA, DHFP, DHS)));
        check_eq("d_vsync", 32'(d_vsync), 32'(!m_sync_low((q / DHT) % DVT, DVA, DVFP, DVS)));
        check_eq("d_fs", 32'(d_frame_start), 32'((q % DFT) == 0));
      end
    end
  end

  // Advance the small instance to (frame, v, h); returns 2 time units after that edge.
  task automatic goto_pos(input int fr, input int v, input int h);
    int t = fr * SFT + v * SHT + h;
    int n = 0;
    while (k < t && n < 60000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("goto_reached", 32'(k), 32'(t));
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem_s[i] = 16'($urandom);
      mem_d[i] = 16'h0000;
    end
    mem_d[0] = 16'h8001;
    for (int i = 0; i < 32; i++) begin
      fsr_s[i] = 0;
      fsr_d[i] = 0;
    end
    s_start_row = 8'd0;
    d_start_row = 8'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_hsync", 32'(s_hsync), 32'd1);
    check_eq("async_rst_addr", 32'(d_rd_addr), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("fs_rel_cycle1", 32'(s_frame_start), 32'd0);
    @(posedge clk); #1;
    check_eq("fs_rel_cycle2_s", 32'(s_frame_start), 32'd1);
    check_eq("fs_rel_cycle2_d", 32'(d_frame_start), 32'd1);

    goto_pos(0, 2, 0);
    check_eq("f0_line2_base", 32'(s_rd_addr), 32'(SWPR));
    goto_pos(0, 3, 0);
    s_start_row = 8'(SROWS - 1);
    goto_pos(1, 0, 0);
    check_eq("wrap_line0_base", 32'(s_rd_addr), 32'((SROWS - 1) * SWPR));
    goto_pos(1, 2, 0);
    check_eq("wrap_line2_base", 32'(s_rd_addr), 32'd0);
    goto_pos(1, 10, 0);
    s_start_row = 8'd250;
    goto_pos(1, 12, 0);
    check_eq("latch_hold", 32'(s_rd_addr), 32'(((SROWS - 1 + 6) % SROWS) * SWPR));
    goto_pos(2, 0, 0);
    check_eq("clamp_base", 32'(s_rd_addr), 32'd0);
    goto_pos(2, 5, 0);
    s_start_row = 8'd5;
    goto_pos(3, 0, 0);
    check_eq("latched_base5", 32'(s_rd_addr), 32'(5 * SWPR));

    for (int fr = 3; fr < 6; fr++) begin
      goto_pos(fr, $urandom_range(0, SVT - 2), $urandom_range(0, SHT - 1));
      s_start_row = 8'($urandom_range(0, 13));
    end

    goto_pos(6, 10, 30);
    rst = 1'b1;
    #1;
    check_eq("midrst_addr", 32'(s_rd_addr), 32'd0);
    check_eq("midrst_hsync", 32'(s_hsync), 32'd1);
    check_eq("midrst_vsync", 32'(s_vsync), 32'd1);
    check_eq("midrst_rgb", 32'(s_rgb), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    goto_pos(0, 2, 0);
    check_eq("post_rst_base", 32'(s_rd_addr), 32'(SWPR));
    for (int fr = 0; fr < 2; fr++) begin
      goto_pos(fr, $urandom_range(3, SVT - 2), $urandom_range(0, SHT - 1));
      s_start_row = 8'($urandom_range(0, 13));
    end
    goto_pos(2, 4, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read-side companion to the 8192 x 16-bit dual-port VGA frame buffer.
- Generates 640x480@60 VGA timing and fetches cell-state words from one buffer port (1-cycle read latency).
- Each 16-bit word is 16 automaton cells, shown 2x2 pixels each: 320x240 logical cells, 20 words per row, 4800 words per screen.
- Supports vertical scrolling through a programmable start row, so the automaton can use the buffer as a circular row store.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- FG_COLOR, 12'hFFF, RGB444 colour for a cell bit of 1
- BG_COLOR, 12'h000, RGB444 colour for a cell bit of 0

Ports:
- clk  input  1  pixel clock (25 MHz nominal); sole clock
- rst  input  1  asynchronous, active-high reset
- start_row  input  8  logical row (0..239) shown on the top screen line; sampled once per frame
- rd_addr  output  13  buffer read address; combinational from internal registers
- rd_data  input  16  buffer read data; valid the cycle after rd_addr is presented
- hsync  output  1  horizontal sync, active-low, registered
- vsync  output  1  vertical sync, active-low, registered
- rgb  output  12  pixel colour, registered
- frame_start  output  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters: h_cnt 0..799 wraps to 0 and increments v_cnt; v_cnt 0..524 wraps to 0. Active = h_cnt<640 && v_cnt<480.
- Sync timing, pre-pipeline: hsync low for h_cnt in [656,752); vsync low for v_cnt in [490,492).
- rd_addr = row_base + h_cnt[9:5] while active; 0 otherwise.
- Pixel bit index = 15 - h_cnt[4:1]. Bit 15 is the leftmost cell of the word.
- row_base update at h_cnt==799:
  - If v_cnt==524: row_base <= S*20, where S = start_row latched at that cycle, or 0 if start_row>=240.
  - Else if v_cnt<480 and v_cnt[0]==1: row_base <= row_base+20; if the result is >=4800, subtract 4800 (wrap).
  - Otherwise row_base holds.
- Pipeline, 2-cycle fixed latency:
  - Stage 1 registers bit index, active, hsync_raw, vsync_raw and frame-origin flag (h_cnt==0 && v_cnt==0).
  - Stage 2 registers:
    - rgb = (active1 && rd_data[idx1]) ? FG_COLOR : (active1 ? BG_COLOR : 0)
    - hsync, vsync and frame_start from the stage-1 values.
  - Outputs in cycle n+2 correspond to the counters of cycle n. Sync and pixel stay mutually aligned; the 2-pixel shift against nominal timing is accepted.
- Blanking: rgb=0 whenever not active, regardless of rd_data.
- start_row changes mid-frame have no effect until the next v_cnt==524, h_cnt==799 boundary.
- Reset (async assert, any time including mid-line):
  - h_cnt=0, v_cnt=0, row_base=0, all pipeline registers cleared.
  - hsync=1, vsync=1, rgb=0, frame_start=0.
  - rd_addr=0 while rst is high.
  - First frame after reset shows from row 0. frame_start pulses 2 cycles after reset release.
- Arithmetic: row_base is 13 bits, max 4780. row_base+31 never exceeds 8191; no overflow.

Test Plan:
- Reset release: rst high 5 cycles then low -> outputs held at hsync=1, vsync=1, rgb=0 during reset; rd_addr=0; frame_start=1 exactly at cycle 2 after release.
- Timing: run 2 frames -> hsync low 96 of every 800 cycles; vsync low 1600 consecutive cycles; frame_start period 420000 cycles; rgb=0 outside 640x480.
- Pixel map: word0=16'h8001, all others 0, start_row=0 -> rgb=FG_COLOR at pixels x=0,1 and x=30,31 on lines 0 and 1 only; BG_COLOR elsewhere in active area.
- Addressing: start_row=0 -> rd_addr=21 at (h=32,v=2); rd_addr=4799 at (h=639,v=479); rd_addr=0 during blanking.
- Scroll wrap and latching:
  - start_row=239 -> line 0 base 4780, line 2 base 0.
  - Change start_row to 5 at v=100 -> current frame unchanged; next frame line 0 base 100.
  - start_row=250 -> base 0.
- Mid-line reset: assert rst at (h=300,v=200) for 3 cycles -> immediate idle outputs; after release, counters restart at (0,0) and the first frame is fully correct.
